// File: rtl/calc_frame_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | calc_frame_receiver: reassembles calculator serial symbols into frames    |
// | and holds one completed frame behind a valid/ready handshake.             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module calc_frame_receiver #(
  parameter int INBITS     = 8,
  parameter int SBITS      = 4,
  parameter int FRAME_BITS = 8 + 3 * INBITS
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ClkTx,
  input  logic                  DoutValid,
  input  logic [SBITS-1:0]      DataOut,
  input  logic                  FrameReady,
  output logic                  FrameValid,
  output logic [FRAME_BITS-1:0] FrameData,
  output logic                  FrameErr,
  output logic                  Overrun,
  output logic                  RxBusy,
  output logic [7:0]            FrameCnt
);

  localparam int NSYM = FRAME_BITS / SBITS;
  localparam int CW   = $clog2(NSYM + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  clktx_q;
  logic                  valid_q, valid_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic                  ovr_q, ovr_d;
  logic [7:0]            fcnt_q, fcnt_d;

  logic                  samp;
  logic                  complete;
  logic [FRAME_BITS-1:0] frame_word;

  always_comb begin
    samp       = ClkTx & ~clktx_q;
    frame_word = {shreg_q[FRAME_BITS-SBITS-1:0], DataOut};
    complete   = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (samp && DoutValid) begin
          shreg_d = {{(FRAME_BITS-SBITS){1'b0}}, DataOut};
          cnt_d   = CW'(1);
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        // Losing DoutValid mid-frame aborts even on a cycle with a sample point.
        if (!DoutValid) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (samp) begin
          if (cnt_q == CW'(NSYM - 1)) begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = ST_IDLE;
          end else begin
            shreg_d = frame_word;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    fcnt_d  = fcnt_q;
    ovr_d   = 1'b0;
    if (valid_q && FrameReady) begin
      valid_d = 1'b0;
    end
    // An accept on the completion edge frees the slot for the new frame.
    if (complete) begin
      if (!valid_q || FrameReady) begin
        data_d  = frame_word;
        valid_d = 1'b1;
        fcnt_d  = fcnt_q + 8'd1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      clktx_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      clktx_q <= ClkTx;
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign FrameValid = valid_q;
  assign FrameData  = data_q;
  assign FrameErr   = err_q;
  assign Overrun    = ovr_q;
  assign RxBusy     = (state_q == ST_RECV);
  assign FrameCnt   = fcnt_q;

endmodule
`default_nettype wire
